// File: rtl/cache_axi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cache_axi_pkg
// Purpose  : Shared definitions for the instruction-cache AXI read bridge.
//            Holds the default line length, AXI burst/size/resp encodings
//            and the bridge FSM state type.
// Revision : 1.0 - initial release
// ============================================================================
package cache_axi_pkg;

  // 32-bit words per cache line (64-byte line)
  localparam int LINE_WORDS_DEF = 16;

  // AXI encodings
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // Bridge FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADDR  = 2'd1,
    ST_DATA  = 2'd2,
    ST_DRAIN = 2'd3
  } bridge_state_e;

endpackage : cache_axi_pkg
`default_nettype wire

// File: rtl/ret_beat_buf.sv
`default_nettype none
// ============================================================================
// Module   : ret_beat_buf
// Purpose  : One-entry output buffer holding a data beat and its last flag.
//            Accepts a new beat when empty or when the held beat is being
//            consumed in the same cycle (full throughput, latency 1).
// Ports    : clk, rstn           - clock, async active-low reset
//            in_valid_i/in_ready_o, in_data_i, in_last_i   - fill side
//            out_valid_o/out_ready_i, out_data_o, out_last_o - drain side
// Revision : 1.0 - initial release
// ============================================================================
module ret_beat_buf #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [DW-1:0] in_data_i,
  input  logic          in_last_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] out_data_o,
  output logic          out_last_o
);

  logic          valid_q, valid_d;
  logic          last_q,  last_d;
  logic [DW-1:0] data_q,  data_d;

  assign in_ready_o  = ~valid_q | out_ready_i;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_last_o  = last_q;

  always_comb begin
    valid_d = valid_q;
    last_d  = last_q;
    data_d  = data_q;
    if (in_valid_i && in_ready_o) begin
      // fill wins over drain so a simultaneous drain+fill stays valid
      valid_d = 1'b1;
      last_d  = in_last_i;
      data_d  = in_data_i;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      last_q  <= last_d;
      data_q  <= data_d;
    end
  end

endmodule : ret_beat_buf
`default_nettype wire

// File: rtl/icache_axi_rd_bridge.sv
`default_nettype none
// ============================================================================
// Module   : icache_axi_rd_bridge
// Purpose  : Converts an instruction-cache line-read request into one AXI
//            INCR burst of LINE_WORDS 32-bit beats and returns the beats to
//            the cache through a one-entry buffer.
// Ports    : clk, rstn                         - clock, async active-low reset
//            r_req, r_addr, r_rdy              - cache request
//            r_data_ready, ret_valid, ret_last, r_data - cache beat return
//            arid..arready                     - AXI read address channel
//            rid..rready                       - AXI read data channel
//            rd_err                            - sticky response error flag
// Config   : ICACHE_BRIDGE_ERR_CHECK_EN - when defined, rd_err is set on a
//            bad rresp, wrong rid or misplaced rlast; otherwise tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module icache_axi_rd_bridge
  import cache_axi_pkg::*;
#(
  parameter int         LINE_WORDS = LINE_WORDS_DEF,
  parameter logic [3:0] AXI_ID     = 4'd0
) (
  input  logic        clk,
  input  logic        rstn,
  // cache side
  input  logic        r_req,
  input  logic [31:0] r_addr,
  output logic        r_rdy,
  input  logic        r_data_ready,
  output logic        ret_valid,
  output logic        ret_last,
  output logic [31:0] r_data,
  // AXI AR
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  // AXI R
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  // status
  output logic        rd_err
);

  // byte-offset bits of a line (6 for a 64-byte line)
  localparam int          OFF_BITS  = $clog2(LINE_WORDS) + 2;
  localparam logic [31:0] LINE_MASK = ~((32'd1 << OFF_BITS) - 32'd1);
  localparam logic [3:0]  LAST_CNT  = 4'(LINE_WORDS - 1);

  bridge_state_e state_q, state_d;
  logic [31:0]   addr_q,  addr_d;
  logic [3:0]    cnt_q,   cnt_d;
  logic          buf_in_ready;
  logic          buf_in_valid;
  logic          r_hs;

  // AR fields other than valid/addr are constant for every request
  assign arid    = AXI_ID;
  assign araddr  = addr_q;
  assign arlen   = 8'(LINE_WORDS - 1);
  assign arsize  = AXI_SIZE_4B;
  assign arburst = AXI_BURST_INCR;

  assign buf_in_valid = rvalid & (state_q == ST_DATA);
  assign r_hs         = rvalid & rready;

  // --------------------------------------------------------------------------
  // FSM next-state and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    r_rdy   = 1'b0;
    arvalid = 1'b0;
    rready  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        r_rdy = r_req;
        if (r_req) begin
          addr_d  = r_addr & LINE_MASK;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        arvalid = 1'b1;
        cnt_d   = 4'd0;
        if (arready) state_d = ST_DATA;
      end
      ST_DATA: begin
        rready = buf_in_ready;
        if (rvalid && buf_in_ready) begin
          cnt_d = cnt_q + 4'd1;
          if (rlast) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (ret_valid && ret_last && r_data_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Output beat buffer
  // --------------------------------------------------------------------------
  ret_beat_buf #(
    .DW (32)
  ) u_ret_beat_buf (
    .clk         (clk),
    .rstn        (rstn),
    .in_valid_i  (buf_in_valid),
    .in_ready_o  (buf_in_ready),
    .in_data_i   (rdata),
    .in_last_i   (rlast),
    .out_valid_o (ret_valid),
    .out_ready_i (r_data_ready),
    .out_data_o  (r_data),
    .out_last_o  (ret_last)
  );

  // --------------------------------------------------------------------------
  // Response checking
  // --------------------------------------------------------------------------
`ifdef ICACHE_BRIDGE_ERR_CHECK_EN
  logic err_q, err_d;
  logic beat_bad;

  assign beat_bad = (rresp != AXI_RESP_OKAY) || (rid != AXI_ID) ||
                    (rlast && (cnt_q != LAST_CNT)) ||
                    (!rlast && (cnt_q == LAST_CNT));

  always_comb begin
    err_d = err_q;
    if (r_hs && beat_bad) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign rd_err = err_q;
`else
  // response fields and beat count are only consumed by the checker
  logic unused_chk;
  assign unused_chk = ^{rid, rresp, cnt_q, r_hs, LAST_CNT};
  assign rd_err     = 1'b0;
`endif

endmodule : icache_axi_rd_bridge
`default_nettype wire

// File: tb/tb_icache_axi_rd_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_icache_axi_rd_bridge
// Purpose  : Self-checking bench for icache_axi_rd_bridge. A queue-based
//            reference model predicts returned beats, rready, rd_err and
//            the AR request for each randomized line read.
// Revision : 1.0 - initial release
// ============================================================================
module tb_icache_axi_rd_bridge;

  localparam int LW = 16;
`ifdef ICACHE_BRIDGE_ERR_CHECK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic        r_req;
  logic [31:0] r_addr;
  logic        r_rdy;
  logic        r_data_ready;
  logic        ret_valid;
  logic        ret_last;
  logic [31:0] r_data;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic        rd_err;

  int   n_cmp = 0;
  int   n_bad = 0;
  logic err_exp = 1'b0;

  always #5 clk = ~clk;

  icache_axi_rd_bridge #(
    .LINE_WORDS (LW),
    .AXI_ID     (4'd0)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .r_req        (r_req),
    .r_addr       (r_addr),
    .r_rdy        (r_rdy),
    .r_data_ready (r_data_ready),
    .ret_valid    (ret_valid),
    .ret_last     (ret_last),
    .r_data       (r_data),
    .arid         (arid),
    .araddr       (araddr),
    .arlen        (arlen),
    .arsize       (arsize),
    .arburst      (arburst),
    .arvalid      (arvalid),
    .arready      (arready),
    .rid          (rid),
    .rdata        (rdata),
    .rresp        (rresp),
    .rlast        (rlast),
    .rvalid       (rvalid),
    .rready       (rready),
    .rd_err       (rd_err)
  );

  // One complete line read. Called on a negedge with the DUT idle; returns
  // on a negedge with the DUT idle again (or just out of reset on abort).
  task automatic run_line(input logic [31:0] addr, input int ar_dly,
                          input int rdy_pct, input int vld_pct,
                          input int err_beat, input int abort_beat,
                          input logic [31:0] dbase);
    logic [31:0] exp_addr;
    logic [31:0] q_data[$];
    logic        q_last[$];
    int          sent, got, budget;
    logic        hs, hs_prev, exp_rready;

    exp_addr = {addr[31:6], 6'b0};
    r_req  = 1'b1;
    r_addr = addr;
    #1;
    n_cmp++;
    if (r_rdy !== 1'b1) begin
      n_bad++;
      $display("FAIL req_accept: r_rdy=%0b required 1", r_rdy);
    end
    @(posedge clk); @(negedge clk);

    // address phase; keep requesting with a different address meanwhile
    r_addr = $urandom;
    for (int i = 0; i <= ar_dly; i++) begin
      arready = (i == ar_dly);
      #1;
      n_cmp++;
      if ({arvalid, araddr, arlen, arsize, arburst, arid, r_rdy, rready} !==
          {1'b1, exp_addr, 8'd15, 3'd2, 2'd1, 4'd0, 1'b0, 1'b0}) begin
        n_bad++;
        $display("FAIL ar_fields: vld=%0b addr=%h len=%0d size=%0d burst=%0d id=%0d r_rdy=%0b rready=%0b required 1 %h 15 2 1 0 0 0",
                 arvalid, araddr, arlen, arsize, arburst, arid, r_rdy, rready, exp_addr);
      end
      @(posedge clk); @(negedge clk);
    end
    arready = 1'b0;

    sent = 0; got = 0; budget = 0; hs_prev = 1'b0;
    while (got < LW && budget < 400) begin
      budget++;
      n_cmp++;
      if (rd_err !== err_exp) begin
        n_bad++;
        $display("FAIL rd_err: got %0b required %0b", rd_err, err_exp);
      end
      if (hs_prev) begin
        n_cmp++;
        if (ret_valid !== 1'b1) begin
          n_bad++;
          $display("FAIL ret_latency: ret_valid=%0b required 1 after beat", ret_valid);
        end
      end
      if (ret_valid === 1'b1) begin
        n_cmp++;
        if (q_data.size() == 0) begin
          n_bad++;
          $display("FAIL spurious_beat: data=%h required no beat", r_data);
        end else if ({r_data, ret_last} !== {q_data[0], q_last[0]}) begin
          n_bad++;
          $display("FAIL beat_data: data=%h last=%0b required %h %0b",
                   r_data, ret_last, q_data[0], q_last[0]);
        end
      end

      if (abort_beat >= 0 && sent == abort_beat) begin
        rvalid = 1'b0; r_data_ready = 1'b0; r_req = 1'b0;
        rstn = 1'b0;
        #1;
        n_cmp++;
        if ({r_rdy, arvalid, rready, ret_valid, ret_last, rd_err, r_data, araddr} !== '0) begin
          n_bad++;
          $display("FAIL async_reset: r_rdy=%0b arvalid=%0b rready=%0b ret_valid=%0b ret_last=%0b rd_err=%0b r_data=%h araddr=%h required all 0",
                   r_rdy, arvalid, rready, ret_valid, ret_last, rd_err, r_data, araddr);
        end
        err_exp = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        return;
      end

      rvalid       = (sent < LW) && ($urandom_range(0, 99) < vld_pct);
      rdata        = dbase + sent;
      rlast        = (sent == LW - 1);
      rresp        = (sent == err_beat) ? 2'b10 : 2'b00;
      rid          = 4'd0;
      r_data_ready = ($urandom_range(0, 99) < rdy_pct);
      r_req        = 1'($urandom_range(0, 1));
      r_addr       = $urandom;
      #1;
      exp_rready = (sent < LW) && (!ret_valid || r_data_ready);
      n_cmp++;
      if ({rready, r_rdy} !== {exp_rready, 1'b0}) begin
        n_bad++;
        $display("FAIL rready_busy: rready=%0b r_rdy=%0b required %0b 0",
                 rready, r_rdy, exp_rready);
      end
      hs = rvalid && rready;
      if (hs) begin
        q_data.push_back(rdata);
        q_last.push_back(rlast);
        if (sent == err_beat) err_exp = ERR_EN;
        sent++;
      end
      if (ret_valid && r_data_ready) begin
        got++;
        if (q_data.size() > 0) begin
          void'(q_data.pop_front());
          void'(q_last.pop_front());
        end
      end
      @(posedge clk); @(negedge clk);
      hs_prev = hs;
    end

    rvalid = 1'b0; r_data_ready = 1'b0; r_req = 1'b0;
    n_cmp++;
    if (budget >= 400) begin
      n_bad++;
      $display("FAIL line_timeout: beats consumed %0d required %0d", got, LW);
    end else if ({ret_valid, arvalid, rready, rd_err} !== {1'b0, 1'b0, 1'b0, err_exp}) begin
      n_bad++;
      $display("FAIL line_end: ret_valid=%0b arvalid=%0b rready=%0b rd_err=%0b required 0 0 0 %0b",
               ret_valid, arvalid, rready, rd_err, err_exp);
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0; r_req = 1'b0; r_addr = '0; r_data_ready = 1'b0;
    arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
    err_exp = 1'b0;
    #1;
    n_cmp++;
    if ({r_rdy, arvalid, rready, ret_valid, ret_last, rd_err, r_data, araddr} !== '0) begin
      n_bad++;
      $display("FAIL reset_state: r_rdy=%0b arvalid=%0b rready=%0b ret_valid=%0b ret_last=%0b rd_err=%0b r_data=%h araddr=%h required all 0",
               r_rdy, arvalid, rready, ret_valid, ret_last, rd_err, r_data, araddr);
    end
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_line;
    run_line(32'h1C00_0024, 5, 100, 100, -1, -1, 32'h100);
  endtask

  task automatic test_stall;
    run_line($urandom, $urandom_range(0, 3), 45, 70, -1, -1, $urandom);
  endtask

  task automatic test_err_resp;
    run_line($urandom, 1, 80, 90, 7, -1, $urandom);
    run_line($urandom, 0, 80, 90, -1, -1, $urandom);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 3; i++)
      run_line($urandom, $urandom_range(0, 2), 85, 85, -1, -1, $urandom);
  endtask

  task automatic test_reset_mid_burst;
    run_line($urandom, 0, 100, 100, -1, 9, 32'h200);
    run_line($urandom, 1, 75, 80, -1, -1, 32'h300);
  endtask

  initial begin
    test_reset;
    test_single_line;
    test_stall;
    test_err_resp;
    test_back_to_back;
    test_reset_mid_burst;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_icache_axi_rd_bridge
`default_nettype wire

// File: doc/icache_axi_rd_bridge.md
ICACHE_AXI_RD_BRIDGE -- requirements
Module: icache_axi_rd_bridge

Interface
REQ-001 SHALL have parameter LINE_WORDS, 16, 32-bit words per cache line (64-byte line).
REQ-002 SHALL have parameter AXI_ID, 4'd0, constant ARID value driven on every request.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have cache-side ports: r_req in 1 line-read request; r_addr in 32 request address; r_rdy out 1 request accepted; r_data_ready in 1 cache can take a beat; ret_valid out 1 beat valid; ret_last out 1 final beat; r_data out 32 beat data.
REQ-006 SHALL have AXI AR ports: arid out 4; araddr out 32; arlen out 8; arsize out 3; arburst out 2; arvalid out 1; arready in 1.
REQ-007 SHALL have AXI R ports: rid in 4; rdata in 32; rresp in 2; rlast in 1; rvalid in 1; rready out 1.
REQ-008 SHALL have port rd_err  out  1  sticky error flag (see Configuration).

Function
REQ-009 SHALL implement FSM states IDLE, ADDR, DATA, DRAIN.
REQ-010 IDLE: r_rdy SHALL equal r_req combinationally; on r_req=1, SHALL latch {r_addr[31:6],6'b0} and go to ADDR next cycle.
REQ-011 r_rdy SHALL be 0 in every state other than IDLE; requests arriving while busy are held by the cache, not dropped.
REQ-012 ADDR: arvalid=1, araddr=latched address, arlen=LINE_WORDS-1, arsize=3'b010, arburst=2'b01 (INCR), arid=AXI_ID; all AR fields stable until arvalid&arready; then go to DATA.
REQ-013 DATA: rready SHALL be 1 iff the one-entry output buffer is empty or r_data_ready=1 in that cycle.
REQ-014 On rvalid&rready SHALL load rdata and end-of-line flag into the output buffer; ret_valid/r_data/ret_last appear the following cycle (latency 1 from R handshake).
REQ-015 Output buffer SHALL hold its beat while ret_valid=1 and r_data_ready=0; SHALL clear on r_data_ready=1 unless reloaded the same cycle (simultaneous drain+fill keeps ret_valid=1).
REQ-016 A 4-bit beat counter SHALL reset to 0 in ADDR and increment on each R handshake, wrapping 15->0.
REQ-017 End-of-line flag SHALL be rlast; on the handshake with rlast=1 SHALL go to DRAIN.
REQ-018 DRAIN: SHALL return to IDLE the cycle the buffered last beat is consumed (ret_valid&ret_last&r_data_ready).
REQ-019 Back-to-back: a new r_req SHALL be accepted in the first IDLE cycle after DRAIN; no beat of one line ever mixes with the next.

Reset
REQ-020 On rstn=0 (any state, including mid-burst) SHALL go to IDLE with r_rdy, arvalid, rready, ret_valid, ret_last, rd_err=0, r_data=0, araddr=0, counter=0.
REQ-021 Reset SHALL take effect asynchronously; release is synchronous to clk.

Configuration
REQ-022 Macro ICACHE_BRIDGE_ERR_CHECK_EN: when defined, rd_err SHALL set (sticky until reset) on any R handshake with rresp!=2'b00, rid!=AXI_ID, rlast=1 at counter!=15, or rlast=0 at counter=15; data is forwarded unchanged regardless.
REQ-023 When undefined, rd_err SHALL be tied 0 and no check logic instantiated.

Structure
REQ-024 Shared package cache_axi_pkg SHALL hold LINE_WORDS default, AXI burst/size/resp constants, and the FSM state typedef.
REQ-025 The one-entry output buffer SHALL be sub-module ret_beat_buf (data+last, valid/ready in and out).

Verification
REQ-026 r_req=1, r_addr=0x1C00_0024 in IDLE -> r_rdy=1 same cycle; next cycle arvalid=1, araddr=0x1C00_0000, arlen=15, arsize=2, arburst=1.
REQ-027 arready held 0 for 5 cycles -> AR fields constant, no second request accepted (r_rdy=0).
REQ-028 16 beats rdata=0x100+i, r_data_ready=1 -> ret_valid one cycle after each handshake, r_data=0x100+i in order, ret_last only on beat 15, back in IDLE after.
REQ-029 r_data_ready=0 for 3 cycles mid-burst -> rready=0 while buffer full, beat held unchanged, no loss or duplication.
REQ-030 With ICACHE_BRIDGE_ERR_CHECK_EN, rresp=2'b10 on beat 7 -> rd_err=1 from next cycle, held through subsequent lines; without macro rd_err stays 0.
REQ-031 rstn=0 asserted at beat 9 -> all outputs 0 immediately, FSM IDLE; fresh request after release completes a full 16-beat line.
